// File: rtl/tri_bus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// The state encoding is fixed so that waveforms and debug taps stay stable.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_HOLD_MAX = 8;

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
// The request vector is doubled so that the wrap becomes a plain linear scan.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W  = $clog2(N);
    localparam int PW = $clog2(2 * N);

    logic [2*N-1:0] dbl;
    logic [PW-1:0]  pos;

    assign dbl = {req, req};

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = PW'(ptr) + PW'(i);
            if (!valid && dbl[pos]) begin
                valid = 1'b1;
                idx   = (pos >= PW'(N)) ? W'(pos - PW'(N)) : W'(pos);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus; each gnt bit is a driver enable.
// A one-cycle turnaround with every enable low separates any two bus owners.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter  int N        = DEFAULT_N,
    parameter  int HOLD_MAX = DEFAULT_HOLD_MAX,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] owner,
    output logic         busy,
    output logic         turn
);
    localparam int             CNT_W      = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [W-1:0]     LAST_IDX   = W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_d;
    logic [W-1:0]     owner_d;
    logic             turn_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick_valid;
    logic [W-1:0]     pick_idx;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        owner_d = owner;
        turn_d  = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (req[owner] && cnt_q < HOLD_MAX_C) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Releasing owner drops to lowest priority by moving ptr past it.
                    state_d = TURN;
                    gnt_d   = '0;
                    turn_d  = 1'b1;
                    ptr_d   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            turn    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            busy    <= |gnt_d;
            turn    <= turn_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter (N=4, HOLD_MAX=4) driven by hand-computed vectors.
// Stimulus pushes the expected post-edge outputs; a negedge monitor pops and compares.
module tb_tri_bus_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       turn;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       turn;

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    logic [3:0] prev_gnt;

    tri_bus_arbiter #(.N(4), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .turn  (turn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive req before an edge, then record what the outputs must be after it.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o, input logic t);
        exp_t e;
        req = r;
        @(posedge clk);
        e.gnt   = g;
        e.owner = o;
        e.turn  = t;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",   32'(gnt),   32'(e.gnt));
            check("owner", 32'(owner), 32'(e.owner));
            check("busy",  32'(busy),  32'(e.gnt != 4'b0000));
            check("turn",  32'(turn),  32'(e.turn));
        end
        check("gnt_onehot0",   32'($onehot0(gnt)), 32'd1);
        check("busy_vs_turn",  32'(busy && turn), 32'd0);
        check("handover_gap",
              32'(prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt), 32'd0);
        prev_gnt = rst ? 4'b0000 : gnt;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_gnt = 4'b0000;
        rst      = 1'b1;
        req      = 4'b0000;
        #7;
        check("reset_gnt",   32'(gnt),   32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_turn",  32'(turn),  32'd0);
        #5;
        rst = 1'b0;

        // Round robin with all requesting: owners 0,1,2,3,0, four cycles each.
        for (int k = 0; k < 4; k++) begin
            repeat (4) step(4'b1111, 4'(1 << k), k[1:0], 1'b0);
            step(4'b1111, 4'b0000, k[1:0], 1'b1);
        end
        repeat (4) step(4'b1111, 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 2 for three cycles, then turnaround and idle.
        repeat (3) step(4'b0100, 4'b0100, 2'd2, 1'b0);
        step(4'b0000, 4'b0000, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 2'd2, 1'b0);

        // Lone requester 0 held: four grant cycles then one turn, repeating.
        for (int c = 0; c < 12; c++)
            step(4'b0001, (c % 5 == 4) ? 4'b0000 : 4'b0001, 2'd0, (c % 5 == 4));
        step(4'b0000, 4'b0000, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b0);

        // Owner 1 drops while 3 raises on the same edge: turn cycle first.
        repeat (2) step(4'b0010, 4'b0010, 2'd1, 1'b0);
        step(4'b1000, 4'b0000, 2'd1, 1'b1);
        step(4'b1000, 4'b1000, 2'd3, 1'b0);
        step(4'b1000, 4'b1000, 2'd3, 1'b0);

        // Owner 3 hits the hold limit with req 1001: ptr wraps and 0 wins.
        repeat (2) step(4'b1001, 4'b1000, 2'd3, 1'b0);
        step(4'b1001, 4'b0000, 2'd3, 1'b1);
        step(4'b1001, 4'b0001, 2'd0, 1'b0);
        step(4'b0001, 4'b0001, 2'd0, 1'b0);

        // Asynchronous reset between edges while owner 0 holds the bus.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt",   32'(gnt),   32'd0);
        check("async_rst_busy",  32'(busy),  32'd0);
        check("async_rst_turn",  32'(turn),  32'd0);
        check("async_rst_owner", 32'(owner), 32'd0);
        req = 4'b0010;
        @(negedge clk);
        #2;
        rst = 1'b0;
        step(4'b0010, 4'b0010, 2'd1, 1'b0);
        step(4'b0000, 4'b0000, 2'd1, 1'b1);
        step(4'b0000, 4'b0000, 2'd1, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
